// File: rtl/i2s_rx_multi.sv
// Stereo I2S / left-justified receiver: MSB-first capture, L/R pairing, sign extension to OUT_WIDTH.
// frame_valid pulses 1 SCLK after the edge that ends a right slot; pure streaming sink, no backpressure.
module i2s_rx_multi #(
    parameter int RESOLUTION = 24,
    parameter int SLOT_BITS  = 32,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                 SCLK,
    input  logic                 RST,
    input  logic                 LRCK,
    input  logic                 data_in,
    input  logic                 mode,
    output logic [OUT_WIDTH-1:0] data_out_L,
    output logic [OUT_WIDTH-1:0] data_out_R,
    output logic                 frame_valid,
    output logic                 slot_err
);
    localparam logic [1:0] SEEK = 2'd0;
    localparam logic [1:0] RX_L = 2'd1;
    localparam logic [1:0] RX_R = 2'd2;
    localparam logic [8:0] RES9  = 9'(RESOLUTION);
    localparam logic [8:0] SLOT9 = 9'(SLOT_BITS);

    logic [1:0]            state, state_n;
    logic                  lr_q, mode_q, first_slot;
    logic [7:0]            pos, pos_n;
    logic [RESOLUTION-1:0] shift, shift_n, l_hold;
    logic                  lr_edge, mode_chg, left_lvl, capture, len_bad;
    logic [8:0]            kidx;

    function automatic logic [OUT_WIDTH-1:0] sxt(input logic [RESOLUTION-1:0] w);
        logic signed [OUT_WIDTH-1:0] r;
        r = OUT_WIDTH'($signed(w));
        return r;
    endfunction

    assign lr_edge  = (LRCK != lr_q);
    assign mode_chg = (mode != mode_q);
    assign left_lvl = (LRCK == mode_q);
    assign pos_n    = lr_edge ? 8'd0 : ((pos == 8'hFF) ? 8'hFF : pos + 8'd1);
    // I2S puts the MSB one cycle after the edge; a negative index wraps high and is ignored
    assign kidx     = {1'b0, pos_n} - {8'd0, ~mode_q};
    assign len_bad  = (({1'b0, pos} + 9'd1) != SLOT9);

    always_comb begin
        state_n = state;
        if (lr_edge) begin
            case (state)
                SEEK:    if (left_lvl) state_n = RX_L;
                RX_L:    state_n = RX_R;
                RX_R:    state_n = RX_L;
                default: state_n = SEEK;
            endcase
        end
        capture = (state_n != SEEK) && (kidx < RES9);
        shift_n = lr_edge ? '0 : shift;
        for (int i = 0; i < RESOLUTION; i++) begin
            if (capture && (kidx == 9'(RESOLUTION - 1 - i))) shift_n[i] = data_in;
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            state       <= SEEK;
            lr_q        <= LRCK;
            pos         <= 8'd0;
            shift       <= '0;
            l_hold      <= '0;
            mode_q      <= mode;
            first_slot  <= 1'b0;
            data_out_L  <= '0;
            data_out_R  <= '0;
            frame_valid <= 1'b0;
            slot_err    <= 1'b0;
        end else begin
            lr_q        <= LRCK;
            pos         <= pos_n;
            frame_valid <= 1'b0;
            if (mode_chg) begin
                mode_q <= mode;
                state  <= SEEK;
                l_hold <= '0;
            end else begin
                state <= state_n;
                shift <= shift_n;
                if (lr_edge) begin
                    if (state == RX_L) l_hold <= shift;
                    if (state == RX_R) begin
                        data_out_L  <= sxt(l_hold);
                        data_out_R  <= sxt(shift);
                        frame_valid <= 1'b1;
                    end
                    // the left slot entered from SEEK is exempt from the length check
                    if ((state != SEEK) && !first_slot && len_bad) slot_err <= 1'b1;
                    first_slot <= (state == SEEK) && (state_n == RX_L);
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx_multi.sv
// Bench for i2s_rx_multi: 24-bit and 16-bit instances on one stream, slot-level reference model.
module tb_i2s_rx_multi;
    logic        SCLK = 1'b0;
    logic        RST = 1'b1, LRCK = 1'b0, data_in = 1'b0, mode = 1'b0;
    logic [23:0] l24, r24, l16, r16;
    logic        fv24, err24, fv16, err16;

    always #5 SCLK = ~SCLK;

    i2s_rx_multi dut (
        .SCLK(SCLK), .RST(RST), .LRCK(LRCK), .data_in(data_in), .mode(mode),
        .data_out_L(l24), .data_out_R(r24), .frame_valid(fv24), .slot_err(err24)
    );
    i2s_rx_multi #(.RESOLUTION(16), .SLOT_BITS(32), .OUT_WIDTH(24)) dut16 (
        .SCLK(SCLK), .RST(RST), .LRCK(LRCK), .data_in(data_in), .mode(mode),
        .data_out_L(l16), .data_out_R(r16), .frame_valid(fv16), .slot_err(err16)
    );

    int total = 0, bad = 0, cyc = 0, fv_cnt = 0;
    logic chk_en = 1'b0;
    logic cur_lr = 1'b0, cur_mode = 1'b0;

    // reference model state
    logic        m_lr_prev, m_mode, m_first;
    int          m_phase;            // 0 searching, 1 in left slot, 2 in right slot
    logic        slot_q[$];
    logic [23:0] m_lw24, m_lw16;
    logic        exp_fv, exp_err;
    logic [23:0] exp_l24, exp_r24, exp_l16, exp_r16;

    task automatic cmp(input string nm, input logic [49:0] act, input logic [49:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic logic [23:0] word_of(input int res, input int dly);
        logic [23:0] w;
        int idx;
        w = '0;
        for (int b = 0; b < res; b++) begin
            idx = b + dly;
            if (idx < slot_q.size()) w[res-1-b] = slot_q[idx];
        end
        return w;
    endfunction

    function automatic logic [23:0] sx16(input logic [23:0] w);
        return {{8{w[15]}}, w[15:0]};
    endfunction

    task automatic model_cycle(input logic rst, input logic lr, input logic d, input logic md);
        logic e;
        int dly;
        if (rst) begin
            exp_fv = 0; exp_err = 0;
            exp_l24 = 0; exp_r24 = 0; exp_l16 = 0; exp_r16 = 0;
            m_phase = 0; m_first = 0; m_mode = md; m_lr_prev = lr;
            m_lw24 = 0; m_lw16 = 0;
            slot_q.delete();
            chk_en = 1'b1;
        end else begin
            exp_fv = 0;
            e = (lr != m_lr_prev);
            m_lr_prev = lr;
            dly = m_mode ? 0 : 1;
            if (md != m_mode) begin
                m_mode = md;
                m_phase = 0;
            end else if (e) begin
                if (m_phase == 1) begin
                    if (!m_first && slot_q.size() != 32) exp_err = 1;
                    m_lw24 = word_of(24, dly);
                    m_lw16 = word_of(16, dly);
                    m_first = 0;
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    if (slot_q.size() != 32) exp_err = 1;
                    exp_l24 = m_lw24;
                    exp_r24 = word_of(24, dly);
                    exp_l16 = sx16(m_lw16);
                    exp_r16 = sx16(word_of(16, dly));
                    exp_fv = 1;
                    m_phase = 1;
                end else if (lr == m_mode) begin
                    m_phase = 1;
                    m_first = 1;
                end
            end
            if (e) slot_q.delete();
            slot_q.push_back(d);
        end
    endtask

    task automatic check_outputs();
        if (fv24 === 1'b1) fv_cnt++;
        cmp("dut24", {fv24, err24, l24, r24}, {exp_fv, exp_err, exp_l24, exp_r24});
        cmp("dut16", {fv16, err16, l16, r16}, {exp_fv, exp_err, exp_l16, exp_r16});
    endtask

    task automatic step(input logic rst, input logic lr, input logic d, input logic md);
        @(negedge SCLK);
        if (chk_en) check_outputs();
        RST = rst; LRCK = lr; data_in = d; mode = md;
        model_cycle(rst, lr, d, md);
        cyc++;
    endtask

    // one LRCK slot: toggles LRCK, sends w MSB first with the current format's delay
    task automatic slot(input int len, input logic [23:0] w, input int flip_at,
                        input int rst_a, input int rst_b);
        cur_lr = ~cur_lr;
        for (int j = 0; j < len; j++) begin
            int b;
            logic d;
            if (j == flip_at) cur_mode = ~cur_mode;
            b = j - (cur_mode ? 0 : 1);
            d = (b >= 0 && b < 24) ? w[23-b] : 1'($urandom);
            step((j >= rst_a) && (j < rst_b), cur_lr, d, cur_mode);
        end
    endtask

    task automatic frame_slot(input int len, input logic [23:0] lw, input logic [23:0] rw);
        slot(len, ((~cur_lr) == cur_mode) ? lw : rw, -1, -1, -1);
    endtask

    task automatic align_left(input logic [23:0] lw, input logic [23:0] rw);
        if ((~cur_lr) != cur_mode) frame_slot(32, lw, rw);
    endtask

    typedef struct {
        logic        md;
        logic [23:0] tl, tr, el24, er24, el16, er16;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int base;
        tbl[0] = '{1'b0, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 24'hFF8000, 24'h007FFF};
        tbl[1] = '{1'b1, 24'h800000, 24'h123400, 24'h800000, 24'h123400, 24'hFF8000, 24'h001234};
        tbl[2] = '{1'b0, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        tbl[3] = '{1'b1, 24'h7FFFFF, 24'h80FF00, 24'h7FFFFF, 24'h80FF00, 24'h007FFF, 24'hFF80FF};
        tbl[4] = '{1'b0, 24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h001234, 24'hFFABCD};

        repeat (3) step(1'b1, cur_lr, 1'b0, cur_mode);
        cmp("rst_out24", {fv24, err24, l24, r24}, 50'd0);
        cmp("rst_out16", {fv16, err16, l16, r16}, 50'd0);

        // format vectors; each mode switch lands mid left slot and must not disturb outputs
        for (int v = 0; v < 5; v++) begin
            if (tbl[v].md != cur_mode) begin
                align_left(tbl[v-1].tl, tbl[v-1].tr);
                slot(32, tbl[v].tl, 10, -1, -1);
                base = fv_cnt;
                frame_slot(32, tbl[v].tl, tbl[v].tr);
                cmp("hold_fv", 50'(fv_cnt - base), 50'd0);
                cmp("hold24", {l24, r24}, {tbl[v-1].el24, tbl[v-1].er24});
                cmp("hold16", {l16, r16}, {tbl[v-1].el16, tbl[v-1].er16});
                repeat (6) frame_slot(32, tbl[v].tl, tbl[v].tr);
            end else begin
                repeat (8) frame_slot(32, tbl[v].tl, tbl[v].tr);
            end
            cmp("tbl_l24", 50'(l24), 50'(tbl[v].el24));
            cmp("tbl_r24", 50'(r24), 50'(tbl[v].er24));
            cmp("tbl_l16", 50'(l16), 50'(tbl[v].el16));
            cmp("tbl_r16", 50'(r16), 50'(tbl[v].er16));
            cmp("tbl_err", {err24, err16}, 50'd0);
        end

        // reset released in the middle of a right slot
        if ((~cur_lr) == cur_mode) frame_slot(32, 24'h123456, 24'hABCDEF);
        slot(32, 24'h2468AC, -1, 10, 13);
        base = fv_cnt;
        frame_slot(32, 24'h13579B, 24'h2468AC);
        frame_slot(32, 24'h13579B, 24'h2468AC);
        cmp("rst_mid_fv", 50'(fv_cnt - base), 50'd0);
        cmp("rst_mid_out", {l24, r24}, 50'd0);
        frame_slot(32, 24'h13579B, 24'h2468AC);
        cmp("rst_mid_fv1", 50'(fv_cnt - base), 50'd1);
        cmp("rst_mid_24", {l24, r24}, {24'h13579B, 24'h2468AC});
        cmp("rst_mid_16", {l16, r16}, {24'h001357, 24'h002468});

        // LRCK stuck for 300 cycles straight after reset
        repeat (2) step(1'b1, cur_lr, 1'b0, cur_mode);
        base = fv_cnt;
        repeat (300) step(1'b0, cur_lr, 1'($urandom), cur_mode);
        cmp("stuck_fv", 50'(fv_cnt - base), 50'd0);
        cmp("stuck_err", {err24, err16}, 50'd0);
        repeat (8) frame_slot(32, 24'hFEDCBA, 24'h012345);
        cmp("stuck_24", {l24, r24}, {24'hFEDCBA, 24'h012345});
        cmp("stuck_16", {l16, r16}, {24'hFFFEDC, 24'h000123});
        cmp("stuck_err2", {err24, err16}, 50'd0);

        // one 30-cycle left slot: flagged, still delivered
        align_left(24'hFEDCBA, 24'h012345);
        frame_slot(30, 24'hC3C3C3, 24'h3C3C3C);
        frame_slot(32, 24'hC3C3C3, 24'h3C3C3C);
        frame_slot(32, 24'hC3C3C3, 24'h3C3C3C);
        cmp("short_err", {err24, err16}, 50'd3);
        cmp("short_24", {l24, r24}, {24'hC3C3C3, 24'h3C3C3C});
        cmp("short_16", {l16, r16}, {24'hFFC3C3, 24'h003C3C});
        repeat (6) frame_slot(32, 24'h111111, 24'hEEEEEE);
        cmp("after_24", {l24, r24}, {24'h111111, 24'hEEEEEE});
        cmp("after_16", {l16, r16}, {24'h001111, 24'hFFEEEE});
        cmp("after_err", {err24, err16}, 50'd3);

        // random slot lengths, data and mode flips against the model
        slot(32, 24'h0, -1, 0, 2);
        for (int n = 0; n < 60; n++) begin
            int r, len, flip;
            r = $urandom_range(0, 19);
            len = 32;
            flip = -1;
            if (r < 4) len = $urandom_range(20, 40);
            else if (r == 4) len = 260;
            if (r == 5) flip = $urandom_range(0, len - 1);
            slot(len, 24'($urandom), flip, -1, -1);
        end
        @(negedge SCLK);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
